// File: rtl/ring_code_checker_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ring_code_checker_pkg                                      |
// | Description : Shared types and constants for the ring code checker:     |
// |               weight-ordered code table, error-type and FSM encodings.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package ring_code_checker_pkg;

   // FSM states of the checker core
   typedef enum logic [1:0] {
      ST_ACQUIRE = 2'd0,
      ST_LOCKED  = 2'd1,
      ST_FAULT   = 2'd2
   } state_t;

   // ERR_TYPE encodings reported per sample
   typedef enum logic [1:0] {
      ERR_NONE   = 2'd0,
      ERR_ONEHOT = 2'd1,
      ERR_CODE   = 2'd2,
      ERR_SEQ    = 2'd3
   } err_type_t;

   // Code expected on C for each ring index; element [15] is written first.
   // Codes are ordered by weight: 0, the singles, the pairs, the triples, 1111.
   localparam logic [15:0][3:0] c_code_table = {
      4'b1111, 4'b0111, 4'b1011, 4'b1101,   // idx 15..12
      4'b1110, 4'b0110, 4'b1100, 4'b1010,   // idx 11..8
      4'b1001, 4'b0101, 4'b0011, 4'b1000,   // idx 7..4
      4'b0100, 4'b0010, 4'b0001, 4'b0000    // idx 3..0
   };

   function automatic logic [3:0] code_of(input logic [3:0] idx);
      return c_code_table[idx];
   endfunction

endpackage
`default_nettype wire

// File: rtl/ring_code_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ring_code_checker_if                                       |
// | Description : Sample/status bundle between a ring producer (master) and  |
// |               the ring code checker (slave).                             |
// |   EN, CLR, Q[15:0], C[3:0]          : master -> checker                  |
// |   LOCK, ERR, ERR_TYPE, ERR_CNT[7:0],                                     |
// |   POS[3:0], FAULT                   : checker -> master                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface ring_code_checker_if;
   import ring_code_checker_pkg::*;

   logic        EN;
   logic        CLR;
   logic [15:0] Q;
   logic [3:0]  C;
   logic        LOCK;
   logic        ERR;
   err_type_t   ERR_TYPE;
   logic [7:0]  ERR_CNT;
   logic [3:0]  POS;
   logic        FAULT;

   modport master (
      output EN, CLR, Q, C,
      input  LOCK, ERR, ERR_TYPE, ERR_CNT, POS, FAULT
   );

   modport slave (
      input  EN, CLR, Q, C,
      output LOCK, ERR, ERR_TYPE, ERR_CNT, POS, FAULT
   );

endinterface
`default_nettype wire

// File: rtl/ring_code_checker_onehot_index.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : onehot_index                                               |
// | Description : Combinational decode of a 16-bit one-hot vector.           |
// |   i_q[15:0]  : vector to decode                                          |
// |   o_idx[3:0] : position of the set bit (highest set bit if multi-hot)    |
// |   o_valid    : 1 when exactly one bit of i_q is set                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module onehot_index (
   input  wire logic [15:0] i_q,
   output logic      [3:0]  o_idx,
   output logic             o_valid
);

   logic [4:0] w_count;

   always_comb begin
      o_idx   = 4'd0;
      w_count = 5'd0;
      for (int i = 0; i < 16; i++) begin
         if (i_q[i]) begin
            o_idx   = 4'(i);
            w_count = w_count + 5'd1;
         end
      end
   end

   assign o_valid = (w_count == 5'd1);

endmodule
`default_nettype wire

// File: rtl/ring_code_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ring_code_checker                                          |
// | Description : Checks a one-hot ring counter and its weight-ordered code. |
// |               Flags non-one-hot samples, code mismatches and sequence    |
// |               breaks; tracks lock, error count and a sticky fault.       |
// |   CLK, RST_N : clock, asynchronous active-low reset                      |
// |   bus        : slave side of ring_code_checker_if                        |
// |   LOCK_CNT   : clean samples needed to lock (1..15)                      |
// |   ERR_LIMIT  : ERR_CNT value that forces FAULT (1..255)                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ring_code_checker
   import ring_code_checker_pkg::*;
#(
   parameter int LOCK_CNT  = 4,
   parameter int ERR_LIMIT = 8
) (
   input  wire logic          CLK,
   input  wire logic          RST_N,
   ring_code_checker_if.slave bus
);

   logic [3:0] w_idx;
   logic       w_valid;

   state_t     r_state,      w_state_nxt;
   logic [3:0] r_run,        w_run_nxt;
   logic       r_prev_valid, w_prev_valid_nxt;
   logic [3:0] r_pos,        w_pos_nxt;
   logic       r_err,        w_err_nxt;
   err_type_t  r_err_type,   w_err_type_nxt;
   logic [7:0] r_err_cnt,    w_err_cnt_nxt;

   err_type_t  w_type;
   logic [7:0] w_cnt_inc;

   onehot_index u_onehot_index (
      .i_q     (bus.Q),
      .o_idx   (w_idx),
      .o_valid (w_valid)
   );

   // Classification of the current sample, highest priority first
   always_comb begin
      w_type = ERR_NONE;
      if (!w_valid) begin
         w_type = ERR_ONEHOT;
      end else if (bus.C != code_of(w_idx)) begin
         w_type = ERR_CODE;
      end else if (r_prev_valid && (w_idx != r_pos + 4'd1)) begin
         // 4-bit add wraps, so 15 -> 0 is a legal step
         w_type = ERR_SEQ;
      end
   end

   assign w_cnt_inc = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

   always_comb begin
      w_state_nxt      = r_state;
      w_run_nxt        = r_run;
      w_prev_valid_nxt = r_prev_valid;
      w_pos_nxt        = r_pos;
      w_err_nxt        = 1'b0;
      w_err_type_nxt   = r_err_type;
      w_err_cnt_nxt    = r_err_cnt;

      if (bus.CLR) begin
         w_state_nxt      = ST_ACQUIRE;
         w_run_nxt        = 4'd0;
         w_prev_valid_nxt = 1'b0;
         w_err_type_nxt   = ERR_NONE;
         w_err_cnt_nxt    = 8'd0;
      end else if (bus.EN) begin
         w_err_type_nxt   = w_type;
         w_err_nxt        = (w_type != ERR_NONE);
         w_prev_valid_nxt = w_valid;
         if (w_valid) begin
            w_pos_nxt = w_idx;
         end
         if (w_err_nxt) begin
            w_err_cnt_nxt = w_cnt_inc;
         end

         // The error limit overrides every lock transition
         if (w_err_cnt_nxt >= 8'(ERR_LIMIT)) begin
            w_state_nxt = ST_FAULT;
         end else begin
            case (r_state)
               ST_ACQUIRE: begin
                  if (w_err_nxt) begin
                     w_run_nxt = 4'd0;
                  end else begin
                     w_run_nxt = r_run + 4'd1;
                     if (r_run + 4'd1 == 4'(LOCK_CNT)) begin
                        w_state_nxt = ST_LOCKED;
                     end
                  end
               end
               ST_LOCKED: begin
                  if (w_err_nxt) begin
                     w_run_nxt   = 4'd0;
                     w_state_nxt = ST_ACQUIRE;
                  end
               end
               ST_FAULT: begin
                  w_state_nxt = ST_FAULT;
               end
               default: begin
                  w_state_nxt = ST_ACQUIRE;
                  w_run_nxt   = 4'd0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state      <= ST_ACQUIRE;
         r_run        <= 4'd0;
         r_prev_valid <= 1'b0;
         r_pos        <= 4'd0;
         r_err        <= 1'b0;
         r_err_type   <= ERR_NONE;
         r_err_cnt    <= 8'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_run        <= w_run_nxt;
         r_prev_valid <= w_prev_valid_nxt;
         r_pos        <= w_pos_nxt;
         r_err        <= w_err_nxt;
         r_err_type   <= w_err_type_nxt;
         r_err_cnt    <= w_err_cnt_nxt;
      end
   end

   assign bus.LOCK     = (r_state == ST_LOCKED);
   assign bus.FAULT    = (r_state == ST_FAULT);
   assign bus.ERR      = r_err;
   assign bus.ERR_TYPE = r_err_type;
   assign bus.ERR_CNT  = r_err_cnt;
   assign bus.POS      = r_pos;

endmodule
`default_nettype wire

// File: doc/ring_code_checker.md
Name: ring_code_checker

Overview:
- Downstream consumer of the 16-bit one-hot ring counter and its 4-bit weight-ordered encoder output.
- Samples the one-hot vector Q and the code C every enabled clock.
- Checks that Q is one-hot, that C is the correct encoding of Q's index, and that the index advances by exactly +1 (mod 16) per sample.
- Reports lock status, per-sample error pulses, error type and a saturating error count; enters sticky FAULT after too many errors.

Parameters:
LOCK_CNT, 4, consecutive clean samples required to declare lock (1..15)
ERR_LIMIT, 8, ERR_CNT value at which FSM enters FAULT (1..255)

Ports:
CLK  input  1  clock; all state updates on posedge
RST_N  input  1  asynchronous active-low reset
EN  input  1  sample enable; when 0 no state changes
CLR  input  1  synchronous clear of ERR_CNT and FAULT; returns FSM to ACQUIRE
Q  input  16  one-hot ring value
C  input  4  encoded ring value
LOCK  output  1  1 while FSM in LOCKED
ERR  output  1  one-cycle pulse, registered, for an erroneous sample
ERR_TYPE  output  2  0 none, 1 not-one-hot, 2 code mismatch, 3 sequence break; held until next sample
ERR_CNT  output  8  total error samples since reset/CLR, saturates at 255
POS  output  4  index of last valid one-hot sample
FAULT  output  1  1 while FSM in FAULT

Behaviour:
- Reset is async, RST_N=0. Outputs after reset: LOCK=0, ERR=0, ERR_TYPE=0, ERR_CNT=0, POS=0, FAULT=0. FSM=ACQUIRE, run counter=0, prev_valid=0.
- Latency: all outputs are registered and reflect the sample taken at the same posedge (1-cycle latency from input change).
- Index decode: idx = position of the set bit. Q is one-hot iff exactly one bit is set; Q=0 and multi-hot are both errors.
- Code table, idx:code (C[3:0]): 0:0000 1:0001 2:0010 3:0100 4:1000 5:0011 6:0101 7:1001 8:1010 9:1100 10:0110 11:1110 12:1101 13:1011 14:0111 15:1111.
- Checks on each EN=1 sample, with priority one-hot > code > sequence:
  - Not one-hot: ERR_TYPE=1. POS is held. prev_valid is cleared.
  - One-hot but C != table[idx]: ERR_TYPE=2. POS=idx. prev_valid=1.
  - Clean one-hot/code but prev_valid=1 and idx != POS+1 (4-bit wrap, so 15->0 is legal): ERR_TYPE=3. POS=idx.
  - Otherwise the sample is clean: ERR_TYPE=0, POS=idx, prev_valid=1.
  - The first sample after reset/CLR/a not-one-hot sample skips the sequence check.
- Error sample: ERR=1 for that cycle and ERR_CNT+1, saturating at 255. Otherwise ERR=0.
- EN=0: ERR=0. All other state is held.
- FSM:
  - ACQUIRE: a clean sample increments the run counter; an error clears it. When the run reaches LOCK_CNT, go to LOCKED and LOCK=1 on that same registered edge.
  - LOCKED: an error goes to ACQUIRE with run=0 and LOCK drops.
  - Any state: if ERR_CNT reaches ERR_LIMIT, go to FAULT, with priority over the LOCK transitions.
  - FAULT: sticky. LOCK=0, FAULT=1. Checks and ERR_CNT updates continue. Exit only via CLR or reset.
- CLR=1 (synchronous, priority over EN): ERR_CNT=0, FAULT=0, ERR=0, ERR_TYPE=0, run=0, prev_valid=0, FSM=ACQUIRE. POS is held.
- Reset asserted mid-operation: all outputs go to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package holds:
  - the 16-entry code table constant
  - the ERR_TYPE encodings (NONE/ONEHOT/CODE/SEQ)
  - the FSM state encodings (ACQUIRE/LOCKED/FAULT)
- Sub-module onehot_index: combinational; Q in, idx[3:0] and valid out. It is reused by other consumers of the ring.
- Checker core: FSM, counters and output registers.

Test Plan:
- Reset, then a clean ring from idx 0 with correct codes, EN=1 -> LOCK=1 at the 4th sample edge, ERR never 1, POS tracks 0,1,2,3..., and the 15->0 wrap gives no error.
- While locked, inject Q=16'h0003 for one sample -> ERR=1, ERR_TYPE=1, POS held, LOCK=0, ERR_CNT=1. The next clean sample gets no sequence error, and relock takes 4 more clean samples.
- Q=idx 8 (16'h0100) with C=4'b1000 -> ERR_TYPE=2, POS=8. Next sample idx 9/C=1100 is clean.
- Clean samples idx 3 then idx 5 with correct codes -> ERR_TYPE=3 on the second, POS=5, ERR_CNT increments.
- 8 consecutive Q=0 samples -> FAULT=1 after the 8th, LOCK stays 0. Clean samples keep FAULT=1. CLR -> FAULT=0, ERR_CNT=0. 255+ errors with ERR_LIMIT=255 -> ERR_CNT holds at 255.
- EN=0 for 5 cycles mid-lock -> no output changes. Assert RST_N=0 between clock edges -> outputs go to reset values before the next posedge.
